// File: rtl/bcd_seg7_scan.sv
// bcd_seg7_scan: latches NUM_DIGITS packed BCD digits and scans them onto a common-anode 7-segment display.
// Latency: display outputs are registered one cycle behind the scan state; a load shows from the next slot sampled after it.
// Backpressure: none, load is level-sampled every cycle. Optional macro LEADING_ZERO_BLANK_EN blanks leading zeros.
module bcd_seg7_scan #(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [2:0]              digit_idx
);
    localparam int            CW         = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] CNT_LAST   = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYCLES == 0) ? 0 : BLANK_CYCLES - 1);
    localparam logic [2:0]    IDX_LAST   = 3'(NUM_DIGITS - 1);

    typedef enum logic {BLANK, SHOW} state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [2:0]              idx_q, idx_d;
    logic                    slot_end;
    logic [4*NUM_DIGITS-1:0] shadow_q;
    logic [NUM_DIGITS-1:0]   shadow_dp_q;
    logic [3:0]              held_q, held_d;
    logic                    held_dp_q, held_dp_d;
    logic                    held_blank_q, held_blank_d;
    logic [3:0]              sample_dig;
    logic                    sample_dp;
    logic                    sample_blank;
    logic [6:0]              seg_q;
    logic                    dp_q;
    logic [NUM_DIGITS-1:0]   an_q;

    // Active-low {g,f,e,d,c,b,a}; codes above 9 render as a dash
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return 7'h3F;
        endcase
    endfunction

    // Slot counter and digit index advance; idx_d is the digit owning the next cycle
    always_comb begin
        slot_end = (cnt_q == CNT_LAST);
        cnt_d    = slot_end ? '0 : cnt_q + CW'(1);
        idx_d    = idx_q;
        if (slot_end) begin
            idx_d = (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;
        end
    end

    // Pick the shadow digit (and its leading-zero status) for the slot about to enter SHOW
    always_comb begin
        sample_dig   = 4'd0;
        sample_dp    = 1'b0;
        sample_blank = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_d == 3'(k)) begin
                sample_dig = shadow_q[4*k +: 4];
                sample_dp  = shadow_dp_q[k];
            end
        end
`ifdef LEADING_ZERO_BLANK_EN
        sample_blank = (idx_d != 3'd0);
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if ((3'(k) >= idx_d) && (shadow_q[4*k +: 4] != 4'd0)) begin
                sample_blank = 1'b0;
            end
        end
`endif
    end

    // BLANK/SHOW sequencing; the held digit is frozen on entry to SHOW so a slot never tears
    always_comb begin
        state_d      = state_q;
        held_d       = held_q;
        held_dp_d    = held_dp_q;
        held_blank_d = held_blank_q;
        case (state_q)
            BLANK: begin
                if ((BLANK_CYCLES == 0) || (cnt_q == BLANK_LAST)) begin
                    state_d      = SHOW;
                    held_d       = sample_dig;
                    held_dp_d    = sample_dp;
                    held_blank_d = sample_blank;
                end
            end
            SHOW: begin
                if (slot_end) begin
                    if (BLANK_CYCLES == 0) begin
                        held_d       = sample_dig;
                        held_dp_d    = sample_dp;
                        held_blank_d = sample_blank;
                    end else begin
                        state_d = BLANK;
                    end
                end
            end
            default: state_d = BLANK;
        endcase
    end

    // Scan state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= BLANK;
            cnt_q        <= '0;
            idx_q        <= 3'd0;
            held_q       <= 4'd0;
            held_dp_q    <= 1'b0;
            held_blank_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            held_q       <= held_d;
            held_dp_q    <= held_dp_d;
            held_blank_q <= held_blank_d;
        end
    end

    // Shadow capture of the incoming digits, every cycle load is high
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_q    <= '0;
            shadow_dp_q <= '0;
        end else if (load) begin
            shadow_q    <= digits_in;
            shadow_dp_q <= dp_in;
        end
    end

    // Registered display drive, one cycle behind the scan state
    always_ff @(posedge clk) begin
        if (reset) begin
            seg_q <= 7'h7F;
            dp_q  <= 1'b1;
            an_q  <= '1;
        end else if (state_q == SHOW) begin
            seg_q <= held_blank_q ? 7'h7F : bcd_to_seg(held_q);
            dp_q  <= ~held_dp_q;
            an_q  <= ~(NUM_DIGITS'(1) << idx_q);
        end else begin
            seg_q <= 7'h7F;
            dp_q  <= 1'b1;
            an_q  <= '1;
        end
    end

    assign seg       = seg_q;
    assign dp        = dp_q;
    assign an        = an_q;
    assign digit_idx = idx_q;

endmodule

// File: tb/tb_bcd_seg7_scan.sv
// Testbench for bcd_seg7_scan: directed loads, expected slot contents queued per phase.
// A negedge monitor pops one expectation per displayed slot and checks timing and stability.
// Honours LEADING_ZERO_BLANK_EN for the expected blanking of leading zeros.
module tb_bcd_seg7_scan;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load = 1'b0;
    logic [15:0] digits_in = 16'h0;
    logic [3:0]  dp_in = 4'h0;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic [2:0]  digit_idx;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    bit   have_cur = 1'b0;
    bit   in_slot = 1'b0;
    bit   abort = 1'b0;
    bit   gap_ok = 1'b0;
    int   low = 0;
    int   gap = 0;
    int   errors = 0;
    int   checks = 0;
    int   n = 0;

    always #5 clk = ~clk;

    bcd_seg7_scan #(.NUM_DIGITS(4), .SCAN_DIV(8), .BLANK_CYCLES(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .digits_in (digits_in),
        .dp_in     (dp_in),
        .load      (load),
        .seg       (seg),
        .dp        (dp),
        .an        (an),
        .digit_idx (digit_idx)
    );

    function automatic logic [6:0] lz(input logic [6:0] s, input bit b);
`ifdef LEADING_ZERO_BLANK_EN
        return b ? 7'h7F : s;
`else
        return s;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic push(input logic [3:0] a, input logic [6:0] s, input logic d);
        exp_t e;
        e.an  = a;
        e.seg = s;
        e.dp  = d;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        n++;
    endtask

    task automatic step_to(input int t);
        while (n < t) tick();
    endtask

    task automatic load_at(input int e, input logic [15:0] dig, input logic [3:0] dpv);
        step_to(e - 1);
        load      = 1'b1;
        digits_in = dig;
        dp_in     = dpv;
        step_to(e);
        load = 1'b0;
    endtask

    // Monitor: one expectation per displayed slot, checked every cycle the anode is low
    always @(negedge clk) begin
        chk("an_onehot", 32'($countones(~an) > 1), 0);
        if (an != 4'hF) begin
            if (!in_slot) begin
                in_slot = 1'b1;
                low     = 0;
                abort   = 1'b0;
                if (gap_ok) chk("blank_gap", gap, 2);
                if (q.size() == 0) begin
                    errors++;
                    checks++;
                    have_cur = 1'b0;
                    $display("FAIL unexpected_slot: got an=%0h expected no slot", an);
                end else begin
                    cur      = q.pop_front();
                    have_cur = 1'b1;
                end
            end
            low++;
            if (have_cur) begin
                chk("slot_an", an, cur.an);
                chk("slot_seg", seg, cur.seg);
                chk("slot_dp", dp, cur.dp);
            end
        end else begin
            if (in_slot) begin
                in_slot = 1'b0;
                if (!abort) chk("slot_len", low, 6);
                gap    = 0;
                gap_ok = !abort;
            end
            gap++;
            chk("idle_seg", seg, 7'h7F);
            chk("idle_dp", dp, 1);
        end
        if (reset) begin
            abort  = 1'b1;
            gap_ok = 1'b0;
        end
    end

    initial begin
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        n     = 0;
        chk("rst_an", an, 4'hF);
        chk("rst_seg", seg, 7'h7F);
        chk("rst_dp", dp, 1);
        chk("rst_idx", digit_idx, 0);

        // Empty shadow: every slot shows zero
        push(4'hE, 7'h40, 1);
        push(4'hD, lz(7'h40, 1), 1);
        push(4'hB, lz(7'h40, 1), 1);
        push(4'h7, lz(7'h40, 1), 1);
        push(4'hE, 7'h40, 1);

        // 2019 with dp on digit 2
        push(4'hD, 7'h79, 1);
        push(4'hB, 7'h40, 0);
        push(4'h7, 7'h24, 1);
        push(4'hE, 7'h10, 1);
        load_at(40, 16'h2019, 4'b0100);

        // 5634, then digit 1 changed to 7 during its own SHOW
        push(4'hD, 7'h30, 1);
        push(4'hB, 7'h02, 1);
        push(4'h7, 7'h12, 1);
        push(4'hE, 7'h19, 1);
        push(4'hD, 7'h78, 1);
        load_at(70, 16'h5634, 4'b0000);
        load_at(76, 16'h5674, 4'b0000);

        // Invalid codes render as dashes
        push(4'hB, 7'h3F, 1);
        push(4'h7, 7'h3F, 0);
        push(4'hE, 7'h12, 0);
        push(4'hD, 7'h40, 1);
        load_at(110, 16'hFA05, 4'b1001);

        // load held high: last captured value wins
        push(4'hB, 7'h78, 1);
        push(4'h7, lz(7'h40, 1), 1);
        push(4'hE, 7'h40, 1);
        push(4'hD, 7'h40, 1);
        push(4'hB, 7'h78, 1);
        step_to(138);
        load  = 1'b1;
        dp_in = 4'h0;
        for (int i = 1; i <= 7; i++) begin
            digits_in = {4'h0, 4'(i), 8'h00};
            tick();
        end
        load      = 1'b0;
        digits_in = 16'h0900;

        // Reset with load during digit-2 SHOW
        step_to(180);
        chk("pre_rst_idx", digit_idx, 2);
        chk("pre_rst_an", an, 4'hB);
        reset     = 1'b1;
        load      = 1'b1;
        digits_in = 16'h9999;
        dp_in     = 4'hF;
        tick();
        reset     = 1'b0;
        load      = 1'b0;
        digits_in = 16'h0;
        dp_in     = 4'h0;
        n         = 0;
        chk("mid_rst_an", an, 4'hF);
        chk("mid_rst_seg", seg, 7'h7F);
        chk("mid_rst_dp", dp, 1);
        chk("mid_rst_idx", digit_idx, 0);

        push(4'hE, 7'h40, 1);
        push(4'hD, lz(7'h40, 1), 1);
        push(4'hB, lz(7'h40, 1), 1);
        push(4'h7, lz(7'h40, 1), 1);
        step_to(2);
        chk("restart_blank_an", an, 4'hF);
        step_to(3);
        chk("restart_an", an, 4'hE);
        chk("restart_idx", digit_idx, 0);

        // 0050 with dp on digit 3
        push(4'hE, 7'h40, 1);
        push(4'hD, 7'h12, 1);
        push(4'hB, lz(7'h40, 1), 1);
        push(4'h7, lz(7'h40, 1), 0);
        load_at(30, 16'h0050, 4'b1000);

        // All zero: only digit 0 survives blanking
        push(4'hE, 7'h40, 1);
        push(4'hD, lz(7'h40, 1), 1);
        push(4'hB, lz(7'h40, 1), 1);
        push(4'h7, lz(7'h40, 1), 1);
        load_at(62, 16'h0000, 4'b0000);

        step_to(98);
        chk("queue_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
